// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// function-code encodings, FSM state type and small op-decode helpers.
package ex_muldiv_pkg;

    // Function code width and encodings (equal to the instruction funct3)
    localparam int MD_OP_WIDTH = 3;

    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL    = 3'd0;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULH   = 3'd1;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULHSU = 3'd2;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULHU  = 3'd3;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV    = 3'd4;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIVU   = 3'd5;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM    = 3'd6;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_REMU   = 3'd7;

    // Width of the iteration counter and its terminal value (32 iterations)
    localparam int               MD_CNT_WIDTH  = 5;
    localparam logic [4:0]       MD_LAST_COUNT = 5'd31;

    // Controller states
    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } md_state_t;

    // True for the four divide/remainder operations
    function automatic logic md_is_div(input logic [MD_OP_WIDTH-1:0] op);
        return (op == MD_OP_DIV)  || (op == MD_OP_DIVU) ||
               (op == MD_OP_REM)  || (op == MD_OP_REMU);
    endfunction

    // True for the signed divide/remainder pair, the only ops that can overflow
    function automatic logic md_is_signed_div(input logic [MD_OP_WIDTH-1:0] op);
        return (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

    // True for the remainder pair (fast-path results differ from the quotient pair)
    function automatic logic md_is_rem(input logic [MD_OP_WIDTH-1:0] op);
        return (op == MD_OP_REM) || (op == MD_OP_REMU);
    endfunction

    // rs1 is interpreted as two's complement for these ops
    function automatic logic md_op1_signed(input logic [MD_OP_WIDTH-1:0] op);
        return (op == MD_OP_MUL)    || (op == MD_OP_MULH) ||
               (op == MD_OP_MULHSU) || (op == MD_OP_DIV)  ||
               (op == MD_OP_REM);
    endfunction

    // rs2 is interpreted as two's complement for these ops (MULHSU takes rs2 unsigned)
    function automatic logic md_op2_signed(input logic [MD_OP_WIDTH-1:0] op);
        return (op == MD_OP_MUL) || (op == MD_OP_MULH) ||
               (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide unit for the execute stage. One shared
// 32-iteration shift datapath performs radix-2 shift-add multiply and
// restoring division on operand magnitudes; signs are fixed up on entry
// to DONE. Divide-by-zero and signed overflow complete in a single cycle.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   valid_i,
    output logic                   ready_o,
    input  logic [MD_OP_WIDTH-1:0] op_i,
    input  logic [XLEN-1:0]        op1_i,
    input  logic [XLEN-1:0]        op2_i,
    input  logic                   flush_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [XLEN-1:0]        result_o
);

    // Controller state and iteration counter
    md_state_t               state;
    logic [MD_CNT_WIDTH-1:0] count;

    // Latched request: op, sign fix-up flags, divisor/multiplicand magnitude
    logic [MD_OP_WIDTH-1:0]  op_q;
    logic                    neg_res_q;
    logic                    neg_rem_q;
    logic [XLEN-1:0]         mag_b;

    // Shared shift registers: high half is product-high / partial remainder,
    // low half is multiplier / quotient
    logic [XLEN-1:0]         acc_hi;
    logic [XLEN-1:0]         acc_lo;

    // Request decode
    logic                    accept;
    logic                    a_neg;
    logic                    b_neg;
    logic [XLEN-1:0]         a_mag;
    logic [XLEN-1:0]         b_mag;
    logic                    div_zero;
    logic                    div_ovf;
    logic                    fast_path;
    logic [XLEN-1:0]         fast_result;

    // One iteration of each datapath
    logic [XLEN:0]           mul_sum;
    logic [XLEN-1:0]         mul_hi_next;
    logic [XLEN-1:0]         mul_lo_next;
    logic [XLEN:0]           div_shift;
    logic [XLEN:0]           div_diff;
    logic                    div_ge;
    logic [XLEN-1:0]         div_hi_next;
    logic [XLEN-1:0]         div_lo_next;
    logic [XLEN-1:0]         step_hi;
    logic [XLEN-1:0]         step_lo;

    // Final sign fix-up and selection
    logic [2*XLEN-1:0]       product;
    logic [2*XLEN-1:0]       prod_fixed;
    logic [XLEN-1:0]         quot_fixed;
    logic [XLEN-1:0]         rem_fixed;
    logic [XLEN-1:0]         final_result;
    logic                    last_iter;

    // Decode an incoming request: magnitudes, sign flags and fast-path results
    always_comb begin
        accept      = valid_i && (state == MD_IDLE) && !flush_i;
        a_neg       = md_op1_signed(op_i) && op1_i[XLEN-1];
        b_neg       = md_op2_signed(op_i) && op2_i[XLEN-1];
        a_mag       = a_neg ? (-op1_i) : op1_i;
        b_mag       = b_neg ? (-op2_i) : op2_i;
        div_zero    = md_is_div(op_i) && (op2_i == '0);
        div_ovf     = md_is_signed_div(op_i) &&
                      (op1_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (op2_i == '1);
        fast_path   = div_zero || div_ovf;
        fast_result = '0;
        if (div_zero) begin
            fast_result = md_is_rem(op_i) ? op1_i : '1;
        end else if (div_ovf) begin
            fast_result = md_is_rem(op_i) ? '0 : op1_i;
        end
    end

    // One shift-add or restoring-subtract step, plus the fixed-up result of the final step
    always_comb begin
        mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mag_b} : '0);
        mul_hi_next = mul_sum[XLEN:1];
        mul_lo_next = {mul_sum[0], acc_lo[XLEN-1:1]};

        div_shift   = {acc_hi, acc_lo[XLEN-1]};
        div_diff    = div_shift - {1'b0, mag_b};
        div_ge      = !div_diff[XLEN];
        div_hi_next = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        div_lo_next = {acc_lo[XLEN-2:0], div_ge};

        step_hi     = md_is_div(op_q) ? div_hi_next : mul_hi_next;
        step_lo     = md_is_div(op_q) ? div_lo_next : mul_lo_next;

        product     = {step_hi, step_lo};
        prod_fixed  = neg_res_q ? (-product) : product;
        quot_fixed  = neg_res_q ? (-step_lo) : step_lo;
        rem_fixed   = neg_rem_q ? (-step_hi) : step_hi;

        last_iter   = (state == MD_CALC) && (count == MD_LAST_COUNT);

        final_result = '0;
        case (op_q)
            MD_OP_MUL:    final_result = prod_fixed[XLEN-1:0];
            MD_OP_MULH:   final_result = prod_fixed[2*XLEN-1:XLEN];
            MD_OP_MULHSU: final_result = prod_fixed[2*XLEN-1:XLEN];
            MD_OP_MULHU:  final_result = prod_fixed[2*XLEN-1:XLEN];
            MD_OP_DIV:    final_result = quot_fixed;
            MD_OP_DIVU:   final_result = quot_fixed;
            MD_OP_REM:    final_result = rem_fixed;
            MD_OP_REMU:   final_result = rem_fixed;
            default:      final_result = '0;
        endcase
    end

    // Controller: state, iteration counter and the registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= MD_IDLE;
            count   <= '0;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else if (flush_i) begin
            state   <= MD_IDLE;
            count   <= '0;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    if (valid_i) begin
                        count   <= '0;
                        ready_o <= 1'b0;
                        busy_o  <= 1'b1;
                        if (fast_path) begin
                            state  <= MD_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state  <= MD_CALC;
                            done_o <= 1'b0;
                        end
                    end
                end
                MD_CALC: begin
                    count <= count + 1'b1;
                    if (count == MD_LAST_COUNT) begin
                        state  <= MD_DONE;
                        done_o <= 1'b1;
                    end
                end
                MD_DONE: begin
                    state   <= MD_IDLE;
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
                default: begin
                    state   <= MD_IDLE;
                    count   <= '0;
                    ready_o <= 1'b1;
                    busy_o  <= 1'b0;
                    done_o  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath: latch the request at accept, then iterate the shared shift registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= MD_OP_MUL;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            mag_b     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
        end else if (accept) begin
            op_q      <= op_i;
            neg_res_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            mag_b     <= b_mag;
            acc_hi    <= '0;
            acc_lo    <= a_mag;
        end else if (state == MD_CALC) begin
            acc_hi    <= step_hi;
            acc_lo    <= step_lo;
        end
    end

    // Result register: written only on entry to DONE and held otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_o <= '0;
        end else if (!flush_i) begin
            if (accept && fast_path) begin
                result_o <= fast_result;
            end else if (last_iter) begin
                result_o <= final_result;
            end
        end
    end

endmodule
